// File: rtl/layer_seq_ctrl_if.sv
// Handshake/bus bundle between the layer sequencer, the top-level controller,
// and the node/memory pair.
interface layer_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start_top2c;
  logic              done_flag_node2c;
  logic              rd_en_c2mem;
  logic [ADDR_W-1:0] rd_addr_c2mem;
  logic              head_c2node;
  logic [3:0]        data_sel_c2node;
  logic              wr_en_c2mem;
  logic [ADDR_W-1:0] wr_addr_c2mem;
  logic              busy_c2top;
  logic              done_c2top;
  logic              err_c2top;

  modport master (
    input  start_top2c, done_flag_node2c,
    output rd_en_c2mem, rd_addr_c2mem, head_c2node, data_sel_c2node,
           wr_en_c2mem, wr_addr_c2mem, busy_c2top, done_c2top, err_c2top
  );

  modport slave (
    output start_top2c, done_flag_node2c,
    input  rd_en_c2mem, rd_addr_c2mem, head_c2node, data_sel_c2node,
           wr_en_c2mem, wr_addr_c2mem, busy_c2top, done_c2top, err_c2top
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// One layer pass: stream N_INPUTS samples into the node, wait for its done flag,
// then drain N_NEURONS outputs to memory. All outputs registered.
module layer_seq_ctrl #(
  parameter int unsigned N_INPUTS    = 784,
  parameter int unsigned N_NEURONS   = 10,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned OUT_BASE    = 0,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic             clock_c_in,
  input  logic             reset_c_in,
  layer_seq_ctrl_if.master bus
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(N_INPUTS - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(OUT_BASE);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]        NN_LAST   = 4'(N_NEURONS - 1);
  localparam logic [3:0]        NN_ALL    = 4'(N_NEURONS);
  localparam logic [3:0]        SEL_IDLE  = 4'b1111;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_WAIT, S_DRAIN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              head_q, head_d;
  logic [3:0]        sel_q, sel_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [3:0]        cnt_q, cnt_d;

  always_ff @(posedge clock_c_in or posedge reset_c_in) begin
    if (reset_c_in) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      head_q    <= 1'b0;
      sel_q     <= SEL_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      head_q    <= head_d;
      sel_q     <= sel_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    head_d    = rd_en_q;   // data returns one cycle after the read strobe
    sel_d     = sel_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_top2c) begin
          state_d   = S_LOAD;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          tmo_d     = '0;
          cnt_d     = '0;
        end
      end
      S_LOAD: begin
        if (rd_addr_q == LAST_K) begin
          state_d = S_FLUSH;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        // A done flag on the expiry cycle wins over the timeout.
        if (bus.done_flag_node2c) begin
          state_d = S_DRAIN;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FIN;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // cnt_q == N_NEURONS is the lag cycle carrying the last write.
        if (cnt_q == NN_ALL) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_A + ADDR_W'(cnt_q);
          sel_d     = (cnt_q == NN_LAST) ? SEL_IDLE : cnt_q + 4'd1;
          cnt_d     = cnt_q + 4'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rd_en_c2mem     = rd_en_q;
  assign bus.rd_addr_c2mem   = rd_addr_q;
  assign bus.head_c2node     = head_q;
  assign bus.data_sel_c2node = sel_q;
  assign bus.wr_en_c2mem     = wr_en_q;
  assign bus.wr_addr_c2mem   = wr_addr_q;
  assign bus.busy_c2top      = busy_q;
  assign bus.done_c2top      = done_q;
  assign bus.err_c2top       = err_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: a node model drives the done flag, a monitor logs
// per-pass events, and a timing model derived from the pass rules checks them.
module tb_layer_seq_ctrl;

  localparam int NA = 4, NNA = 10, BASEA = 100, TMOA = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_seq_ctrl_if #(.ADDR_W(16)) bus_a ();
  layer_seq_ctrl_if #(.ADDR_W(16)) bus_b ();

  layer_seq_ctrl #(.N_INPUTS(NA), .N_NEURONS(NNA), .ADDR_W(16), .OUT_BASE(BASEA),
                   .TIMEOUT_CYC(TMOA)) dut_a (.clock_c_in(clk), .reset_c_in(rst), .bus(bus_a));
  layer_seq_ctrl #(.N_INPUTS(1), .N_NEURONS(1), .ADDR_W(16), .OUT_BASE(65535),
                   .TIMEOUT_CYC(1023)) dut_b (.clock_c_in(clk), .reset_c_in(rst), .bus(bus_b));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { int cyc; int addr; int data; } ev_t;
  ev_t  rdq[$], wrq[$], selq[$];
  int   headq[$], doneq[$];
  int   busy_cnt;
  logic err_at_done;
  int   cyc;
  int   start_id = 0, seen_id = 0, node_seen = 0;

  logic [15:0] wtab [16];
  logic [15:0] node_q;
  int   node_mode = 1;   // 0: done dly cycles after head falls, 1: never, 2: held high
  int   node_dly  = 0;
  int   node_cnt  = 0;
  logic head_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Node: registered output mux, done flag after a programmable delay.
  always @(posedge clk) node_q <= (bus_a.data_sel_c2node < 4'd10) ? wtab[bus_a.data_sel_c2node] : '0;

  always @(negedge clk) begin
    if (node_seen != start_id) begin
      node_seen = start_id;
      bus_a.done_flag_node2c = 1'b0;
      node_cnt = 0;
    end
    if (node_mode == 1) bus_a.done_flag_node2c = 1'b0;
    else if (node_mode == 2) bus_a.done_flag_node2c = 1'b1;
    else if (head_prev && !bus_a.head_c2node) begin
      if (node_dly == 0) bus_a.done_flag_node2c = 1'b1;
      else node_cnt = node_dly;
    end else if (node_cnt > 0) begin
      node_cnt--;
      if (node_cnt == 0) bus_a.done_flag_node2c = 1'b1;
    end
    head_prev = bus_a.head_c2node;
  end

  always @(negedge clk) begin
    if (seen_id != start_id) begin
      seen_id = start_id;
      cyc = 0; busy_cnt = 0; err_at_done = 1'bx;
      rdq.delete(); wrq.delete(); selq.delete(); headq.delete(); doneq.delete();
    end
    if (start_id != 0) begin
      if (bus_a.rd_en_c2mem) rdq.push_back('{cyc, int'(bus_a.rd_addr_c2mem), 0});
      if (bus_a.head_c2node) headq.push_back(cyc);
      if (bus_a.data_sel_c2node != 4'hF) selq.push_back('{cyc, int'(bus_a.data_sel_c2node), 0});
      if (bus_a.wr_en_c2mem) wrq.push_back('{cyc, int'(bus_a.wr_addr_c2mem), int'(node_q)});
      if (bus_a.done_c2top) begin doneq.push_back(cyc); err_at_done = bus_a.err_c2top; end
      if (bus_a.busy_c2top) busy_cnt++;
      cyc++;
    end
  end

  task automatic set_w();
    for (int i = 0; i < 16; i++) wtab[i] = 16'($urandom);
  endtask

  task automatic start_a();
    @(negedge clk); bus_a.start_top2c = 1'b1;
    @(posedge clk); #1 bus_a.start_top2c = 1'b0;
    start_id++;
  endtask

  task automatic wait_done_a(input string tag);
    logic seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus_a.done_c2top) begin seen = 1'b1; break; end
    end
    chk({tag, ".done_seen"}, seen, 1'b1);
  endtask

  // d: cycle (from accept) whose closing edge first sees the done flag, -1 for never.
  task automatic check_pass(input int n, input int nn, input int base, input int tmo,
                            input int d, input string tag);
    bit ok; int iw, fin, nw;
    ok  = (d >= 0) && (d - (n + 1) < tmo);
    iw  = (d > n + 1) ? d - (n + 1) : 0;
    fin = ok ? n + iw + nn + 3 : n + 1 + tmo;
    nw  = ok ? nn : 0;
    chk({tag, ".rd_n"}, rdq.size(), n);
    for (int k = 0; k < n && k < rdq.size(); k++) begin
      chk({tag, ".rd_addr"}, rdq[k].addr, k);
      chk({tag, ".rd_cyc"}, rdq[k].cyc, k);
    end
    chk({tag, ".head_n"}, headq.size(), n);
    for (int k = 0; k < n && k < headq.size(); k++) chk({tag, ".head_cyc"}, headq[k], k + 1);
    chk({tag, ".sel_n"}, selq.size(), nw);
    for (int j = 0; j < nw && j < selq.size(); j++) begin
      chk({tag, ".sel"}, selq[j].addr, j);
      chk({tag, ".sel_cyc"}, selq[j].cyc, n + 2 + iw + j);
    end
    chk({tag, ".wr_n"}, wrq.size(), nw);
    for (int j = 0; j < nw && j < wrq.size(); j++) begin
      chk({tag, ".wr_addr"}, wrq[j].addr, (base + j) % 65536);
      chk({tag, ".wr_cyc"}, wrq[j].cyc, n + 3 + iw + j);
      chk({tag, ".wr_data"}, wrq[j].data, int'(wtab[j]));
    end
    chk({tag, ".done_n"}, doneq.size(), 1);
    if (doneq.size() > 0) chk({tag, ".done_cyc"}, doneq[0], fin);
    chk({tag, ".err"}, err_at_done, !ok);
    chk({tag, ".busy_cyc"}, busy_cnt, fin + 1);
  endtask

  task automatic run_delay(input int dly, input string tag);
    set_w(); node_mode = 0; node_dly = dly;
    start_a(); wait_done_a(tag); repeat (3) @(negedge clk);
    check_pass(NA, NNA, BASEA, TMOA, NA + 1 + dly, tag);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".rd_en"}, bus_a.rd_en_c2mem, 0);
    chk({tag, ".rd_addr"}, bus_a.rd_addr_c2mem, 0);
    chk({tag, ".head"}, bus_a.head_c2node, 0);
    chk({tag, ".sel"}, bus_a.data_sel_c2node, 4'hF);
    chk({tag, ".wr_en"}, bus_a.wr_en_c2mem, 0);
    chk({tag, ".wr_addr"}, bus_a.wr_addr_c2mem, 0);
    chk({tag, ".busy"}, bus_a.busy_c2top, 0);
    chk({tag, ".done"}, bus_a.done_c2top, 0);
    chk({tag, ".err"}, bus_a.err_c2top, 0);
  endtask

  initial begin
    int heads, writes, wlast, done_at, dsel;
    rst = 1'b1;
    bus_a.start_top2c = 1'b0;
    bus_b.start_top2c = 1'b0;
    bus_b.done_flag_node2c = 1'b0;
    set_w();
    repeat (2) @(negedge clk);
    chk_reset_a("reset");
    chk("reset_b.sel", bus_b.data_sel_c2node, 4'hF);
    chk("reset_b.busy", bus_b.busy_c2top, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_delay(3, "basic");

    set_w(); node_mode = 1;
    start_a(); wait_done_a("timeout"); repeat (3) @(negedge clk);
    check_pass(NA, NNA, BASEA, TMOA, -1, "timeout");
    chk("timeout.err_sticky", bus_a.err_c2top, 1);
    set_w(); node_mode = 0; node_dly = 3;
    start_a();
    chk("restart.err_clr", bus_a.err_c2top, 0);
    wait_done_a("restart"); repeat (3) @(negedge clk);
    check_pass(NA, NNA, BASEA, TMOA, NA + 4, "restart");

    // Stray starts in LOAD, DRAIN and during the done pulse.
    set_w(); node_mode = 0; node_dly = 3;
    start_a();
    @(negedge clk) bus_a.start_top2c = 1'b1;
    @(negedge clk) bus_a.start_top2c = 1'b0;
    dsel = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus_a.data_sel_c2node != 4'hF) begin dsel = 1; break; end
    end
    chk("stray.drain_seen", dsel, 1);
    bus_a.start_top2c = 1'b1;
    @(negedge clk) bus_a.start_top2c = 1'b0;
    wait_done_a("stray");
    bus_a.start_top2c = 1'b1;
    @(negedge clk) bus_a.start_top2c = 1'b0;
    chk("stray.busy_after", bus_a.busy_c2top, 0);
    repeat (3) @(negedge clk);
    chk("stray.rd_after", bus_a.rd_en_c2mem, 0);
    check_pass(NA, NNA, BASEA, TMOA, NA + 4, "stray");

    // Asynchronous reset between edges while k=2 is on the bus.
    node_mode = 0; node_dly = 3;
    start_a();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst.k2", bus_a.rd_addr_c2mem, 2);
    #2 rst = 1'b1;
    #1 chk_reset_a("midrst");
    @(posedge clk); @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    run_delay(3, "post_rst");

    set_w(); node_mode = 2;
    @(negedge clk);
    start_a(); wait_done_a("held"); repeat (3) @(negedge clk);
    check_pass(NA, NNA, BASEA, TMOA, 0, "held");

    run_delay(TMOA - 1, "expiry_edge");
    run_delay(TMOA, "expiry_miss");
    for (int r = 0; r < 6; r++) run_delay(int'($urandom_range(0, 11)), "rand");

    // Minimal configuration with wrapping base address.
    bus_b.done_flag_node2c = 1'b1;
    @(negedge clk) bus_b.start_top2c = 1'b1;
    @(posedge clk); #1 bus_b.start_top2c = 1'b0;
    heads = 0; writes = 0; wlast = -1; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_b.head_c2node) heads++;
      if (bus_b.wr_en_c2mem) begin writes++; wlast = int'(bus_b.wr_addr_c2mem); end
      if (bus_b.done_c2top && done_at < 0) done_at = c;
    end
    chk("edge.heads", heads, 1);
    chk("edge.writes", writes, 1);
    chk("edge.wr_addr", wlast, 16'hFFFF);
    chk("edge.done_cyc", done_at, 1 + 0 + 1 + 3);
    chk("edge.err", bus_b.err_c2top, 0);
    chk("edge.busy", bus_b.busy_c2top, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
